// File: rtl/diffeq_seq_controller.sv
// Sequencing controller for the iterative diffeq solver datapath.
// It steers operand loads and steps through NUM_PHASES compute phases per iteration.
// Iterations repeat while continue_while holds, up to MAX_ITER.
// The result is offered with a valid/ack handshake, and back-to-back solves are allowed.
module diffeq_seq_controller #(
    parameter int NUM_OPERANDS = 4,
    parameter int NUM_PHASES   = 4,
    parameter int ITER_W       = 16,
    parameter int MAX_ITER     = 65535,
    localparam int PH_W        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NUM_OPERANDS-1:0] sel,
    input  logic                    ready,
    input  logic                    compute_done,
    input  logic                    continue_while,
    input  logic                    ack,
    output logic [NUM_OPERANDS-1:0] load,
    output logic [PH_W-1:0]         phase,
    output logic                    phase_start,
    output logic [ITER_W-1:0]       iter_count,
    output logic                    valid,
    output logic                    overflow,
    output logic [2:0]              state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_CHECK   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [NUM_OPERANDS-1:0] ONE_OP  = NUM_OPERANDS'(1);
    localparam logic [PH_W-1:0]         ONE_PH  = PH_W'(1);
    localparam logic [PH_W-1:0]         LAST_PH = PH_W'(NUM_PHASES - 1);
    localparam logic [ITER_W-1:0]       ONE_IT  = ITER_W'(1);
    localparam logic [ITER_W-1:0]       MAX_IT  = ITER_W'(MAX_ITER);

    state_t                  state_q, state_d;
    logic [NUM_OPERANDS-1:0] load_q, load_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic                    phase_start_q, phase_start_d;
    logic [ITER_W-1:0]       iter_q, iter_d;
    logic                    valid_q, valid_d;
    logic                    overflow_q, overflow_d;

    // Next-state logic. Every output is computed here one cycle ahead so that the ports come straight from flops.
    always_comb begin
        state_d       = state_q;
        load_d        = '0;
        phase_d       = phase_q;
        phase_start_d = 1'b0;
        iter_d        = iter_q;
        valid_d       = valid_q;
        overflow_d    = overflow_q;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d    = S_LOAD;
                    iter_d     = '0;
                    overflow_d = 1'b0;
                end
            end
            S_LOAD: begin
                // Isolate the lowest set bit. A sel in the ready cycle still pulses next cycle.
                load_d = sel & (~sel + ONE_OP);
                if (ready) begin
                    state_d       = S_COMPUTE;
                    phase_d       = '0;
                    phase_start_d = 1'b1;
                end
            end
            S_COMPUTE: begin
                if (compute_done) begin
                    if (phase_q == LAST_PH) begin
                        state_d = S_CHECK;
                        phase_d = '0;
                        if (iter_q != MAX_IT) begin
                            iter_d = iter_q + ONE_IT;
                        end
                    end else begin
                        phase_d       = phase_q + ONE_PH;
                        phase_start_d = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (continue_while && (iter_q < MAX_IT)) begin
                    state_d       = S_COMPUTE;
                    phase_d       = '0;
                    phase_start_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    if (continue_while) begin
                        overflow_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                valid_d = 1'b1;
                if (ack) begin
                    valid_d = 1'b0;
                    if (start) begin
                        state_d    = S_LOAD;
                        iter_d     = '0;
                        overflow_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset clears them immediately, even mid-solve.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            load_q        <= '0;
            phase_q       <= '0;
            phase_start_q <= 1'b0;
            iter_q        <= '0;
            valid_q       <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_q        <= load_d;
            phase_q       <= phase_d;
            phase_start_q <= phase_start_d;
            iter_q        <= iter_d;
            valid_q       <= valid_d;
            overflow_q    <= overflow_d;
        end
    end

    assign load        = load_q;
    assign phase       = phase_q;
    assign phase_start = phase_start_q;
    assign iter_count  = iter_q;
    assign valid       = valid_q;
    assign overflow    = overflow_q;
    assign state       = state_q;

endmodule

// File: tb/tb_diffeq_seq_controller.sv
// Directed testbench for diffeq_seq_controller.
// dut uses the default parameters; dut_m uses MAX_ITER=3 for the overflow case.
module tb_diffeq_seq_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  sel = 4'b0;
    logic        ready = 1'b0;
    logic        compute_done = 1'b0;
    logic        continue_while = 1'b0;
    logic        ack = 1'b0;

    logic [3:0]  load, load_m;
    logic [1:0]  phase, phase_m;
    logic        phase_start, phase_start_m;
    logic [15:0] iter_count, iter_count_m;
    logic        valid, valid_m;
    logic        overflow, overflow_m;
    logic [2:0]  state, state_m;

    int checks = 0;
    int errors = 0;
    int ps_count = 0;

    always #5 clk = ~clk;

    diffeq_seq_controller dut (
        .clk(clk), .reset(reset), .start(start), .sel(sel), .ready(ready),
        .compute_done(compute_done), .continue_while(continue_while), .ack(ack),
        .load(load), .phase(phase), .phase_start(phase_start), .iter_count(iter_count),
        .valid(valid), .overflow(overflow), .state(state)
    );

    diffeq_seq_controller #(.MAX_ITER(3)) dut_m (
        .clk(clk), .reset(reset), .start(start), .sel(sel), .ready(ready),
        .compute_done(compute_done), .continue_while(continue_while), .ack(ack),
        .load(load_m), .phase(phase_m), .phase_start(phase_start_m), .iter_count(iter_count_m),
        .valid(valid_m), .overflow(overflow_m), .state(state_m)
    );

    // Advance one clock; observe 1 time unit after the edge and count phase_start pulses of dut.
    task automatic tick();
        @(posedge clk);
        #1;
        if (phase_start === 1'b1) ps_count++;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 0; sel = 0; ready = 0; compute_done = 0; continue_while = 0; ack = 0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (load !== 4'b0 || phase !== 2'd0 || phase_start !== 1'b0)
            begin errors++; $display("FAIL reset_outs: load=%b phase=%0d ps=%b expected 0000/0/0", load, phase, phase_start); end
        checks++; if (iter_count !== 16'd0 || valid !== 1'b0 || overflow !== 1'b0)
            begin errors++; $display("FAIL reset_status: iter=%0d valid=%b ovf=%b expected 0/0/0", iter_count, valid, overflow); end
        tick();
        reset = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_load_sequence();
        logic [3:0] pat [4];
        pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2] = 4'b0100; pat[3] = 4'b1000;
        do_reset();
        start = 1; tick(); start = 0;
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL load_enter: state got %0d expected 1", state); end
        for (int i = 0; i < 4; i++) begin
            sel = pat[i];
            tick();
            checks++; if (load !== pat[i]) begin errors++; $display("FAIL load_seq%0d: got %b expected %b", i, load, pat[i]); end
        end
        sel = 0; ready = 1; tick(); ready = 0;
        checks++; if (state !== 3'd2 || load !== 4'b0)
            begin errors++; $display("FAIL load_to_compute: state=%0d load=%b expected 2/0000", state, load); end
        compute_done = 0; tick();
        checks++; if (load !== 4'b0) begin errors++; $display("FAIL load_zero_compute: got %b expected 0000", load); end
        $display("test_load_sequence done");
    endtask

    task automatic test_priority();
        do_reset();
        start = 1; tick(); start = 0;
        sel = 4'b0110; tick();
        checks++; if (load !== 4'b0010) begin errors++; $display("FAIL priority: got %b expected 0010", load); end
        sel = 4'b1000; ready = 1; tick(); ready = 0; sel = 0;
        checks++; if (state !== 3'd2 || load !== 4'b1000)
            begin errors++; $display("FAIL ready_cycle_sel: state=%0d load=%b expected 2/1000", state, load); end
        tick();
        checks++; if (load !== 4'b0) begin errors++; $display("FAIL load_after_ready: got %b expected 0000", load); end
        $display("test_priority done");
    endtask

    // Two iterations with compute_done on every 3rd cycle, then the DONE handshake.
    task automatic test_iterations();
        do_reset();
        start = 1; tick(); start = 0;
        ps_count = 0;
        ready = 1; continue_while = 1; tick(); ready = 0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (phase !== 2'(k % 4) || phase_start !== 1'b1)
                begin errors++; $display("FAIL phase_entry%0d: phase=%0d ps=%b expected %0d/1", k, phase, phase_start, k % 4); end
            tick();
            if (k == 0) begin
                checks++; if (phase_start !== 1'b0) begin errors++; $display("FAIL ps_one_cycle: got %b expected 0", phase_start); end
            end
            tick();
            compute_done = 1; tick(); compute_done = 0;
            if (k == 3 || k == 7) begin
                checks++; if (state !== 3'd3 || iter_count !== 16'((k + 1) / 4) || valid !== 1'b0)
                    begin errors++; $display("FAIL check_state%0d: state=%0d iter=%0d valid=%b expected 3/%0d/0", k, state, iter_count, valid, (k + 1) / 4); end
                if (k == 7) continue_while = 0;
                tick();
            end
        end
        checks++; if (state !== 3'd4 || valid !== 1'b1 || iter_count !== 16'd2 || overflow !== 1'b0)
            begin errors++; $display("FAIL solve_done: state=%0d valid=%b iter=%0d ovf=%b expected 4/1/2/0", state, valid, iter_count, overflow); end
        checks++; if (ps_count !== 8) begin errors++; $display("FAIL ps_count: got %0d expected 8", ps_count); end
        $display("test_iterations done");
    endtask

    task automatic test_back_to_back();
        start = 1; ack = 0; tick();
        checks++; if (state !== 3'd4 || valid !== 1'b1)
            begin errors++; $display("FAIL start_ignored: state=%0d valid=%b expected 4/1", state, valid); end
        ack = 1; tick(); ack = 0; start = 0;
        checks++; if (state !== 3'd1 || valid !== 1'b0 || iter_count !== 16'd0 || overflow !== 1'b0)
            begin errors++; $display("FAIL ack_start: state=%0d valid=%b iter=%0d ovf=%b expected 1/0/0/0", state, valid, iter_count, overflow); end
        $display("test_back_to_back done");
    endtask

    task automatic test_overflow();
        int n;
        do_reset();
        start = 1; tick(); start = 0;
        ready = 1; continue_while = 1; tick(); ready = 0;
        compute_done = 1;
        n = 0;
        while (state_m !== 3'd4 && n < 40) begin tick(); n++; end
        compute_done = 0;
        checks++; if (n !== 15) begin errors++; $display("FAIL overflow_cycles: got %0d expected 15", n); end
        checks++; if (iter_count_m !== 16'd3 || overflow_m !== 1'b1 || valid_m !== 1'b1)
            begin errors++; $display("FAIL overflow_done: iter=%0d ovf=%b valid=%b expected 3/1/1", iter_count_m, overflow_m, valid_m); end
        checks++; if (state === 3'd4 || overflow !== 1'b0)
            begin errors++; $display("FAIL default_no_cap: state=%0d ovf=%b expected !4/0", state, overflow); end
        continue_while = 0;
        ack = 1; tick(); ack = 0;
        checks++; if (state_m !== 3'd0 || valid_m !== 1'b0 || overflow_m !== 1'b1)
            begin errors++; $display("FAIL ack_idle: state=%0d valid=%b ovf=%b expected 0/0/1", state_m, valid_m, overflow_m); end
        $display("test_overflow done");
    endtask

    task automatic test_async_reset();
        do_reset();
        start = 1; tick(); start = 0;
        ready = 1; continue_while = 1; tick(); ready = 0;
        compute_done = 1; tick(); tick(); compute_done = 0;
        checks++; if (state !== 3'd2 || phase !== 2'd2)
            begin errors++; $display("FAIL mid_compute: state=%0d phase=%0d expected 2/2", state, phase); end
        #2 reset = 1;
        #1;
        checks++; if (state !== 3'd0 || phase !== 2'd0 || phase_start !== 1'b0 || load !== 4'b0)
            begin errors++; $display("FAIL async_reset: state=%0d phase=%0d ps=%b load=%b expected 0/0/0/0000", state, phase, phase_start, load); end
        checks++; if (iter_count !== 16'd0 || valid !== 1'b0 || overflow !== 1'b0)
            begin errors++; $display("FAIL async_reset_status: iter=%0d valid=%b ovf=%b expected 0/0/0", iter_count, valid, overflow); end
        tick();
        reset = 0;
        compute_done = 1; tick(); tick(); compute_done = 0;
        checks++; if (state !== 3'd0 || phase !== 2'd0)
            begin errors++; $display("FAIL idle_ignore: state=%0d phase=%0d expected 0/0", state, phase); end
        continue_while = 0;
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_load_sequence();
        test_priority();
        test_iterations();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
